// File: rtl/bp_pkg.sv
// Shared encodings for the branch predictor and Branch_Result: EX result codes and 2-bit counter states.
package bp_pkg;

    typedef enum logic [1:0] {
        RES_NONE       = 2'b00,
        RES_HIT        = 2'b01,
        RES_MISS_TAKEN = 2'b10,
        RES_MISS_NT    = 2'b11
    } result_t;

    typedef enum logic [1:0] {
        CTR_SN = 2'b00,
        CTR_WN = 2'b01,
        CTR_WT = 2'b10,
        CTR_ST = 2'b11
    } ctr_t;

    localparam ctr_t CTR_INIT  = CTR_WN;
    localparam ctr_t CTR_ALLOC = CTR_WT;

endpackage

// File: rtl/bp_sat_counter.sv
// Next-state logic for a 2-bit saturating counter: up=1 increments toward ST, up=0 decrements toward SN.
module bp_sat_counter
    import bp_pkg::*;
(
    input  ctr_t ctr,
    input  logic up,
    output ctr_t ctr_next
);

    always_comb begin
        ctr_next = ctr;
        if (up && ctr != CTR_ST) begin
            ctr_next = ctr_t'(ctr + 2'd1);
        end else if (!up && ctr != CTR_SN) begin
            ctr_next = ctr_t'(ctr - 2'd1);
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Fetch-stage predictor: direct-mapped BTB with a 2-bit saturating counter per entry, trained from EX.
// Optional macro BP_PERF_CNT_EN adds the Cnt_Branch / Cnt_Miss performance counter ports.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int WIDTH_DATA_LENGTH = 32,
    parameter int ENTRIES           = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [WIDTH_DATA_LENGTH-1:0] PC_F,
    output logic                         Predicted,
    output logic [WIDTH_DATA_LENGTH-1:0] PC_Pre,
    input  logic                         Execute_E,
    input  logic [WIDTH_DATA_LENGTH-1:0] PC_E,
    input  logic [WIDTH_DATA_LENGTH-1:0] PC_ALU,
    input  logic                         Taken_E,
    input  logic [1:0]                   Result
`ifdef BP_PERF_CNT_EN
    ,
    output logic [31:0]                  Cnt_Branch,
    output logic [31:0]                  Cnt_Miss
`endif
);

    localparam int IDX   = $clog2(ENTRIES);
    localparam int TAG_W = WIDTH_DATA_LENGTH - IDX - 2;

    logic [ENTRIES-1:0]           valid;
    logic [TAG_W-1:0]             tag_mem    [ENTRIES];
    logic [WIDTH_DATA_LENGTH-1:0] target_mem [ENTRIES];
    ctr_t                         ctr_mem    [ENTRIES];

    logic [IDX-1:0]   idx_f, idx_e;
    logic [TAG_W-1:0] tag_f, tag_e;
    logic             hit_f, hit_e, upd_en;
    ctr_t             ctr_f, ctr_e, ctr_upd;
    result_t          res;
    logic             unused_pc_low;

    assign idx_f = PC_F[IDX+1:2];
    assign tag_f = PC_F[WIDTH_DATA_LENGTH-1:IDX+2];
    assign idx_e = PC_E[IDX+1:2];
    assign tag_e = PC_E[WIDTH_DATA_LENGTH-1:IDX+2];
    assign unused_pc_low = ^{PC_F[1:0], PC_E[1:0]};

    assign hit_f     = valid[idx_f] && (tag_mem[idx_f] == tag_f);
    assign ctr_f     = ctr_mem[idx_f];
    assign Predicted = hit_f && (ctr_f == CTR_WT || ctr_f == CTR_ST);
    assign PC_Pre    = Predicted ? target_mem[idx_f] : PC_F + WIDTH_DATA_LENGTH'(4);

    assign res    = result_t'(Result);
    assign upd_en = Execute_E && (res != RES_NONE);
    assign hit_e  = valid[idx_e] && (tag_mem[idx_e] == tag_e);
    assign ctr_e  = ctr_mem[idx_e];

    // A taken wrong-target miss always starts from WT/ST, so plain saturating increment lands on ST.
    bp_sat_counter u_sat_counter (
        .ctr      (ctr_e),
        .up       (Taken_E),
        .ctr_next (ctr_upd)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                ctr_mem[i] <= CTR_INIT;
            end
        end else if (upd_en) begin
            if (hit_e) begin
                ctr_mem[idx_e] <= ctr_upd;
            end else if (Taken_E) begin
                valid[idx_e]   <= 1'b1;
                ctr_mem[idx_e] <= CTR_ALLOC;
            end
        end
    end

    // Every taken update either hits (tag unchanged) or allocates, so tag and target share one write enable.
    always_ff @(posedge clk) begin
        if (!rst && upd_en && Taken_E) begin
            tag_mem[idx_e]    <= tag_e;
            target_mem[idx_e] <= PC_ALU;
        end
    end

`ifdef BP_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            Cnt_Branch <= '0;
            Cnt_Miss   <= '0;
        end else if (upd_en) begin
            Cnt_Branch <= Cnt_Branch + 32'd1;
            if (res == RES_MISS_TAKEN || res == RES_MISS_NT) begin
                Cnt_Miss <= Cnt_Miss + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (64 entries, 32-bit PC); index = PC[7:2].
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] PC_F = 32'h0;
    logic        Predicted;
    logic [31:0] PC_Pre;
    logic        Execute_E = 1'b0;
    logic [31:0] PC_E = 32'h0;
    logic [31:0] PC_ALU = 32'h0;
    logic        Taken_E = 1'b0;
    logic [1:0]  Result = 2'b00;
`ifdef BP_PERF_CNT_EN
    logic [31:0] Cnt_Branch;
    logic [31:0] Cnt_Miss;
`endif

    int checks = 0;
    int errors = 0;
    int exp_br = 0;
    int exp_miss = 0;

    branch_predictor #(.WIDTH_DATA_LENGTH(32), .ENTRIES(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .PC_F      (PC_F),
        .Predicted (Predicted),
        .PC_Pre    (PC_Pre),
        .Execute_E (Execute_E),
        .PC_E      (PC_E),
        .PC_ALU    (PC_ALU),
        .Taken_E   (Taken_E),
        .Result    (Result)
`ifdef BP_PERF_CNT_EN
        ,
        .Cnt_Branch(Cnt_Branch),
        .Cnt_Miss  (Cnt_Miss)
`endif
    );

    always #5 clk = ~clk;

    // Present one EX update for a single clock edge, then return #1 after that edge.
    task automatic upd(input logic [31:0] pc, input logic [31:0] alu, input logic taken, input logic [1:0] res);
        Execute_E = 1'b1; PC_E = pc; PC_ALU = alu; Taken_E = taken; Result = res;
        @(posedge clk); #1;
        Execute_E = 1'b0; Result = 2'b00; Taken_E = 1'b0;
        exp_br++;
        if (res[1]) exp_miss++;
    endtask

    task automatic look(input logic [31:0] pc);
        PC_F = pc; #1;
    endtask

    task automatic test_reset;
        PC_F = 32'h1234_0000;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({Predicted, PC_Pre} !== {1'b0, 32'h1234_0004}) begin
                errors++;
                $display("FAIL reset_hold[%0d] got pred=%0b pc=%h want pred=0 pc=12340004", i, Predicted, PC_Pre);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_allocate;
        upd(32'h1234_0000, 32'h1234_0100, 1'b1, 2'b10);
        look(32'h1234_0000);
        checks++;
        if ({Predicted, PC_Pre} !== {1'b1, 32'h1234_0100}) begin
            errors++;
            $display("FAIL alloc_hit got pred=%0b pc=%h want pred=1 pc=12340100", Predicted, PC_Pre);
        end
        look(32'h1234_0004);
        checks++;
        if ({Predicted, PC_Pre} !== {1'b0, 32'h1234_0008}) begin
            errors++;
            $display("FAIL alloc_neighbour got pred=%0b pc=%h want pred=0 pc=12340008", Predicted, PC_Pre);
        end
    endtask

    task automatic test_not_taken;
        upd(32'h1234_0000, 32'h0, 1'b0, 2'b11);
        look(32'h1234_0000);
        checks++;
        if ({Predicted, PC_Pre} !== {1'b0, 32'h1234_0004}) begin
            errors++;
            $display("FAIL nt_first got pred=%0b pc=%h want pred=0 pc=12340004", Predicted, PC_Pre);
        end
        upd(32'h1234_0000, 32'h0, 1'b0, 2'b01);
        checks++;
        if ({Predicted, PC_Pre} !== {1'b0, 32'h1234_0004}) begin
            errors++;
            $display("FAIL nt_second got pred=%0b pc=%h want pred=0 pc=12340004", Predicted, PC_Pre);
        end
    endtask

    // Counter starts at SN: after each taken update 01,10,11,11 -> predictions 0,1,1,1.
    task automatic test_saturate;
        logic [3:0] want;
        want = 4'b1110;
        for (int i = 0; i < 4; i++) begin
            upd(32'h1234_0000, 32'h1234_0100, 1'b1, 2'b01);
            checks++;
            if (Predicted !== want[i]) begin
                errors++;
                $display("FAIL sat_taken[%0d] got pred=%0b want pred=%0b", i, Predicted, want[i]);
            end
        end
        upd(32'h1234_0000, 32'h0, 1'b0, 2'b11);
        checks++;
        if ({Predicted, PC_Pre} !== {1'b1, 32'h1234_0100}) begin
            errors++;
            $display("FAIL sat_dec_from_st got pred=%0b pc=%h want pred=1 pc=12340100", Predicted, PC_Pre);
        end
    endtask

    task automatic test_retarget;
        upd(32'h1234_0000, 32'h1234_FFFF, 1'b1, 2'b10);
        checks++;
        if ({Predicted, PC_Pre} !== {1'b1, 32'h1234_FFFF}) begin
            errors++;
            $display("FAIL retarget got pred=%0b pc=%h want pred=1 pc=1234ffff", Predicted, PC_Pre);
        end
    endtask

    // Not-taken updates that must be ignored: Result NONE, then Execute_E low.
    task automatic test_no_update;
        Execute_E = 1'b1; PC_E = 32'h1234_0000; Taken_E = 1'b0; Result = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        Execute_E = 1'b0; Result = 2'b11;
        repeat (3) @(posedge clk);
        #1;
        Result = 2'b00;
        look(32'h1234_0000);
        checks++;
        if ({Predicted, PC_Pre} !== {1'b1, 32'h1234_FFFF}) begin
            errors++;
            $display("FAIL no_update got pred=%0b pc=%h want pred=1 pc=1234ffff", Predicted, PC_Pre);
        end
    endtask

    task automatic test_back_to_back;
        look(32'h1234_0010);
        Execute_E = 1'b1; PC_E = 32'h1234_0010; PC_ALU = 32'h1234_0400; Taken_E = 1'b1; Result = 2'b10;
        #1;
        checks++;
        if ({Predicted, PC_Pre} !== {1'b0, 32'h1234_0014}) begin
            errors++;
            $display("FAIL same_cycle_pre got pred=%0b pc=%h want pred=0 pc=12340014", Predicted, PC_Pre);
        end
        @(posedge clk); #1;
        Execute_E = 1'b0; Result = 2'b00; Taken_E = 1'b0;
        exp_br++; exp_miss++;
        checks++;
        if ({Predicted, PC_Pre} !== {1'b1, 32'h1234_0400}) begin
            errors++;
            $display("FAIL same_cycle_post got pred=%0b pc=%h want pred=1 pc=12340400", Predicted, PC_Pre);
        end
        look(32'hFFFF_FFFC);
        checks++;
        if ({Predicted, PC_Pre} !== {1'b0, 32'h0000_0000}) begin
            errors++;
            $display("FAIL pc_wrap got pred=%0b pc=%h want pred=0 pc=00000000", Predicted, PC_Pre);
        end
    endtask

    task automatic test_alias;
        upd(32'h5678_0000, 32'h5678_0200, 1'b1, 2'b10);
        look(32'h1234_0000);
        checks++;
        if ({Predicted, PC_Pre} !== {1'b0, 32'h1234_0004}) begin
            errors++;
            $display("FAIL alias_evicted got pred=%0b pc=%h want pred=0 pc=12340004", Predicted, PC_Pre);
        end
        // Not-taken for the evicted tag must not touch the resident entry (ctr WT).
        upd(32'h1234_0000, 32'h0, 1'b0, 2'b11);
        look(32'h5678_0000);
        checks++;
        if ({Predicted, PC_Pre} !== {1'b1, 32'h5678_0200}) begin
            errors++;
            $display("FAIL alias_resident got pred=%0b pc=%h want pred=1 pc=56780200", Predicted, PC_Pre);
        end
    endtask

    task automatic test_perf_counters;
`ifdef BP_PERF_CNT_EN
        checks++;
        if (Cnt_Branch !== 32'(exp_br)) begin
            errors++;
            $display("FAIL cnt_branch got %0d want %0d", Cnt_Branch, exp_br);
        end
        checks++;
        if (Cnt_Miss !== 32'(exp_miss)) begin
            errors++;
            $display("FAIL cnt_miss got %0d want %0d", Cnt_Miss, exp_miss);
        end
`endif
    endtask

    task automatic test_reset_update;
        rst = 1'b1;
        Execute_E = 1'b1; PC_E = 32'h1234_0020; PC_ALU = 32'h1234_0800; Taken_E = 1'b1; Result = 2'b10;
        @(posedge clk); #1;
        rst = 1'b0; Execute_E = 1'b0; Result = 2'b00; Taken_E = 1'b0;
        look(32'h1234_0020);
        checks++;
        if ({Predicted, PC_Pre} !== {1'b0, 32'h1234_0024}) begin
            errors++;
            $display("FAIL reset_drops_update got pred=%0b pc=%h want pred=0 pc=12340024", Predicted, PC_Pre);
        end
        look(32'h5678_0000);
        checks++;
        if ({Predicted, PC_Pre} !== {1'b0, 32'h5678_0004}) begin
            errors++;
            $display("FAIL reset_clears got pred=%0b pc=%h want pred=0 pc=56780004", Predicted, PC_Pre);
        end
        exp_br = 0; exp_miss = 0;
        test_perf_counters();
    endtask

    initial begin
        test_reset();
        test_allocate();
        test_not_taken();
        test_saturate();
        test_retarget();
        test_no_update();
        test_back_to_back();
        test_alias();
        test_perf_counters();
        test_reset_update();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
